// File: rtl/drc_pkg.sv
// Shared AXI constants, FIFO entry layouts and FSM state type for the
// DMA read-controller path writer.
package drc_pkg;

  localparam logic [2:0] SIZE_16B      = 3'b100;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [3:0] CACHE_BUF_MOD = 4'b0011;
  localparam logic [2:0] PROT_DEFAULT  = 3'b000;
  localparam logic [1:0] RESP_OKAY     = 2'b00;

  // Burst entry: {addr[31:0], len[7:0]}
  localparam int BURST_W        = 40;
  localparam int BURST_LEN_LSB  = 0;
  localparam int BURST_LEN_W    = 8;
  localparam int BURST_ADDR_LSB = 8;
  localparam int BURST_ADDR_W   = 32;

  // Data entry: {dwen[3:0], data[127:0]}
  localparam int DATA_W       = 128;
  localparam int DWEN_W       = 4;
  localparam int DWEN_LSB     = 128;
  localparam int DATA_ENTRY_W = 132;
  localparam int STRB_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } drc_state_e;

  // Each dword enable covers four byte lanes of its dword.
  function automatic logic [STRB_W-1:0] dwen_to_strb(input logic [DWEN_W-1:0] dwen);
    logic [STRB_W-1:0] s;
    for (int k = 0; k < DWEN_W; k++) begin
      s[4*k +: 4] = {4{dwen[k]}};
    end
    return s;
  endfunction

endpackage

// File: rtl/drc_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i,
// wrapping modulo P_PATHS.
module drc_rr_arbiter #(
  parameter int P_PATHS = 2,
  localparam int IDX_W = (P_PATHS > 1) ? $clog2(P_PATHS) : 1
) (
  input  logic [P_PATHS-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [P_PATHS-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int off = P_PATHS - 1; off >= 0; off--) begin
      int cand;
      cand = (int'(ptr_i) + off) % P_PATHS;
      if (req_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/drc_path_axi_writer.sv
// Drains per-path burst/data FIFOs into AXI4 INCR write bursts, round-robin
// across paths, and tracks outstanding B responses with a sticky error flag.
module drc_path_axi_writer
  import drc_pkg::*;
#(
  parameter int P_PATHS           = 2,
  parameter int P_MAX_OUTSTANDING = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [P_PATHS*BURST_W-1:0]        paths_burst_in,
  input  logic [P_PATHS-1:0]                paths_burst_empty,
  output logic [P_PATHS-1:0]                paths_burst_rd,
  input  logic [P_PATHS*DATA_ENTRY_W-1:0]   paths_data_in,
  input  logic [P_PATHS-1:0]                paths_data_empty,
  output logic [P_PATHS-1:0]                paths_data_rd,
  output logic [31:0]                       awaddr,
  output logic [7:0]                        awlen,
  output logic [2:0]                        awsize,
  output logic [1:0]                        awburst,
  output logic [3:0]                        awcache,
  output logic [2:0]                        awproto,
  output logic                              awvalid,
  input  logic                              awready,
  output logic [DATA_W-1:0]                 wdata,
  output logic [STRB_W-1:0]                 wstrb,
  output logic                              wlast,
  output logic                              wvalid,
  input  logic                              wready,
  input  logic [1:0]                        bresp,
  input  logic                              bvalid,
  output logic                              bready,
  output logic                              busy,
  output logic                              err,
  output drc_state_e                        dbg_state
);

  localparam int IDX_W = (P_PATHS > 1) ? $clog2(P_PATHS) : 1;
  localparam int OUT_W = $clog2(P_MAX_OUTSTANDING) + 1;

  drc_state_e               state_q, state_d;
  logic [IDX_W-1:0]         sel_q, sel_d, rr_q, rr_d, arb_idx;
  logic [P_PATHS-1:0]       arb_grant, sel_oh;
  logic                     arb_valid;
  logic [BURST_W-1:0]       gnt_entry;
  logic [DATA_ENTRY_W-1:0]  data_entry;
  logic                     data_empty_sel;
  logic [31:0]              addr_q, addr_d;
  logic [7:0]               len_q, len_d, beat_q, beat_d;
  logic [OUT_W-1:0]         out_q, out_d;
  logic                     err_q, err_d;
  logic                     aw_hs, w_hs, b_hs;

  drc_rr_arbiter #(.P_PATHS(P_PATHS)) u_arb (
    .req_i   (~paths_burst_empty),
    .ptr_i   (rr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    gnt_entry      = '0;
    data_entry     = '0;
    data_empty_sel = 1'b1;
    sel_oh         = '0;
    for (int i = 0; i < P_PATHS; i++) begin
      if (arb_grant[i]) gnt_entry = paths_burst_in[i*BURST_W +: BURST_W];
      if (sel_q == IDX_W'(i)) begin
        data_entry     = paths_data_in[i*DATA_ENTRY_W +: DATA_ENTRY_W];
        data_empty_sel = paths_data_empty[i];
        sel_oh[i]      = 1'b1;
      end
    end
  end

  // All channels use AXI valid/ready: a transfer happens on a rising clock
  // edge where both are high; valid and its payload hold until then.
  assign awvalid = (state_q == ST_ADDR);
  assign wvalid  = (state_q == ST_DATA) && !data_empty_sel;
  assign wlast   = (state_q == ST_DATA) && (beat_q == len_q);
  assign bready  = (out_q != '0);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign b_hs    = bvalid && bready;

  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = SIZE_16B;
  assign awburst = BURST_INCR;
  assign awcache = CACHE_BUF_MOD;
  assign awproto = PROT_DEFAULT;
  assign wdata   = data_entry[DATA_W-1:0];
  assign wstrb   = dwen_to_strb(data_entry[DWEN_LSB +: DWEN_W]);

  assign paths_burst_rd = aw_hs ? sel_oh : '0;
  assign paths_data_rd  = w_hs  ? sel_oh : '0;
  assign busy           = (state_q != ST_IDLE) || (out_q != '0);
  assign err            = err_q;
  assign dbg_state      = state_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        if ((out_q < OUT_W'(P_MAX_OUTSTANDING)) && arb_valid) begin
          sel_d   = arb_idx;
          addr_d  = gnt_entry[BURST_ADDR_LSB +: BURST_ADDR_W];
          len_d   = gnt_entry[BURST_LEN_LSB +: BURST_LEN_W];
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (awready) begin
          beat_d  = '0;
          rr_d    = (sel_q == IDX_W'(P_PATHS - 1)) ? '0 : sel_q + 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          beat_d = beat_q + 1'b1;
          if (wlast) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Simultaneous AW and B handshakes cancel, keeping the count exact.
  always_comb begin
    out_d = out_q;
    case ({aw_hs, b_hs})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
    err_d = err_q || (b_hs && (bresp != RESP_OKAY));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      rr_q    <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      rr_q    <= rr_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

endmodule
